// File: rtl/clock_divider_ctrl_if.sv
// clock_divider_ctrl_if: valid/ready handshake carrying a new division factor
interface clock_divider_ctrl_if #(parameter int WIDTH = 8);
   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_ready;
   modport master(output cfg_valid, cfg_div, input cfg_ready);
   modport slave(input cfg_valid, cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: glitch-free ratio change and start/stop sequencer for clock_divider
// CLKDIV_CTRL_TIMEOUT_EN adds a WAIT_LOW watchdog with a timeout_err pulse
module clock_divider_ctrl #(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2
`ifdef CLKDIV_CTRL_TIMEOUT_EN
   , parameter int TIMEOUT  = 1024
`endif
) (
   input  logic                clk_in,
   input  logic                rst,
   clock_divider_ctrl_if.slave cfg,
   input  logic                start,
   input  logic                stop,
   input  logic                div_clk_in,
   output logic                div_rst,
   output logic [WIDTH-1:0]    div_val,
   output logic                running,
   output logic                busy,
   output logic                cfg_err
`ifdef CLKDIV_CTRL_TIMEOUT_EN
   , output logic              timeout_err
`endif
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   typedef enum logic [2:0] {OFF, RUN, WAIT_LOW, LOAD, SETTLE} state_t;
   state_t           state;
   logic             prev, stop_pend, pend_v;
   logic [WIDTH-1:0] pend_div;
   logic [SW-1:0]    scnt;
   logic             acc, ok, fall;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]    tcnt;
`endif
   assign cfg.cfg_ready = state == OFF || (state == RUN && !stop);
   // a cfg offered alongside stop in RUN is still captured so it lands before OFF
   assign acc  = cfg.cfg_valid && (state == OFF || state == RUN);
   assign ok   = |cfg.cfg_div[WIDTH-1:1];
   assign fall = prev && !div_clk_in;
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state     <= OFF;
         div_rst   <= 1'b1;
         div_val   <= WIDTH'(2);
         running   <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
         prev      <= 1'b0;
         stop_pend <= 1'b0;
         pend_v    <= 1'b0;
         pend_div  <= '0;
         scnt      <= '0;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
         tcnt        <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         prev    <= div_clk_in;
         cfg_err <= acc && !ok;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            OFF: begin
               if (acc && ok) div_val <= cfg.cfg_div;
               if (start && !stop) begin
                  state   <= RUN;
                  div_rst <= 1'b0;
                  running <= 1'b1;
               end
            end
            RUN: if ((acc && ok) || stop) begin
               state     <= WAIT_LOW;
               running   <= 1'b0;
               busy      <= 1'b1;
               pend_v    <= acc && ok;
               pend_div  <= cfg.cfg_div;
               stop_pend <= stop;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
               tcnt      <= '0;
`endif
            end
`ifdef CLKDIV_CTRL_TIMEOUT_EN
            WAIT_LOW: if (fall || tcnt == TW'(TIMEOUT - 1)) begin
               state       <= LOAD;
               div_rst     <= 1'b1;
               timeout_err <= !fall;
            end else tcnt <= tcnt + 1'b1;
`else
            WAIT_LOW: if (fall) begin
               state   <= LOAD;
               div_rst <= 1'b1;
            end
`endif
            LOAD: begin
               if (pend_v) div_val <= pend_div;
               pend_v    <= 1'b0;
               stop_pend <= 1'b0;
               scnt      <= '0;
               state     <= stop_pend ? OFF : SETTLE;
               busy      <= !stop_pend;
            end
            SETTLE: if (scnt == SW'(SETTLE_CYC - 1)) begin
               state   <= RUN;
               div_rst <= 1'b0;
               busy    <= 1'b0;
               running <= 1'b1;
            end else scnt <= scnt + 1'b1;
            default: state <= OFF;
         endcase
      end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: scoreboard bench for clock_divider_ctrl with a behavioural divider in the loop
module tb_clock_divider_ctrl;
   localparam int W = 8;
   logic clk_in = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, hold_hi = 1'b0;
   logic div_clk_in, div_rst, running, busy, cfg_err;
   logic [W-1:0] div_val;
   int n_chk = 0, n_fail = 0;
   clock_divider_ctrl_if #(.WIDTH(W)) cfg();
`ifdef CLKDIV_CTRL_TIMEOUT_EN
   logic timeout_err;
   clock_divider_ctrl #(.WIDTH(W), .SETTLE_CYC(2), .TIMEOUT(16)) dut (
      .clk_in(clk_in), .rst(rst), .cfg(cfg), .start(start), .stop(stop), .div_clk_in(div_clk_in),
      .div_rst(div_rst), .div_val(div_val), .running(running), .busy(busy), .cfg_err(cfg_err),
      .timeout_err(timeout_err));
`else
   clock_divider_ctrl #(.WIDTH(W), .SETTLE_CYC(2)) dut (
      .clk_in(clk_in), .rst(rst), .cfg(cfg), .start(start), .stop(stop), .div_clk_in(div_clk_in),
      .div_rst(div_rst), .div_val(div_val), .running(running), .busy(busy), .cfg_err(cfg_err));
`endif
   always #5 clk_in = ~clk_in;
   // divider: toggles every div/2 cycles, held low in reset
   logic q = 1'b0;
   int c = 0;
   always @(posedge clk_in)
      if (div_rst) begin
         q <= 1'b0;
         c <= 0;
      end else if (c >= int'(div_val) / 2 - 1) begin
         q <= ~q;
         c <= 0;
      end else c <= c + 1;
   assign div_clk_in = q | hold_hi;
   typedef enum {S_DV, S_DR, S_RUN, S_BUSY, S_ERR, S_RDY} sig_e;
   typedef struct {string tag; sig_e s; int v;} exp_t;
   exp_t sb[$];
   function automatic logic [31:0] obs(sig_e s);
      case (s)
         S_DV:    return 32'(div_val);
         S_DR:    return 32'(div_rst);
         S_RUN:   return 32'(running);
         S_BUSY:  return 32'(busy);
         S_ERR:   return 32'(cfg_err);
         default: return 32'(cfg.cfg_ready);
      endcase
   endfunction
   task automatic check(string tag, logic [31:0] got, int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic push(string tag, sig_e s, int v);
      sb.push_back('{tag, s, v});
   endtask
   task automatic drain();
      while (sb.size() > 0) begin
         exp_t e = sb.pop_front();
         check(e.tag, obs(e.s), e.v);
      end
   endtask
   task automatic wait_for(string tag, sig_e s, int v, int lim);
      int t = 0;
      while (obs(s) !== v && t < lim) begin
         @(negedge clk_in);
         t++;
      end
      check(tag, obs(s), v);
   endtask
   task automatic period(output int hi, output int per);
      int t = 0;
      hi = 0;
      while (div_clk_in !== 1'b0 && t < 100) begin @(negedge clk_in); t++; end
      while (div_clk_in !== 1'b1 && t < 100) begin @(negedge clk_in); t++; end
      while (div_clk_in === 1'b1 && t < 100) begin @(negedge clk_in); t++; hi++; end
      per = hi;
      while (div_clk_in === 1'b0 && t < 100) begin @(negedge clk_in); t++; per++; end
   endtask
   task automatic send_cfg(int d);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_div = W'(d);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int hi, per, n;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_div = '0;
      repeat (2) @(negedge clk_in);
      push("rst_div_val", S_DV, 2); push("rst_div_rst", S_DR, 1); push("rst_running", S_RUN, 0);
      push("rst_busy", S_BUSY, 0); push("rst_cfg_err", S_ERR, 0); push("rst_ready", S_RDY, 1);
      drain();
      rst = 1'b0;
      @(negedge clk_in);
      send_cfg(4); start = 1'b1;
      push("start_div_val", S_DV, 4); push("start_running", S_RUN, 1); push("start_div_rst", S_DR, 0);
      push("start_busy", S_BUSY, 0);
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0; start = 1'b0;
      drain();
      period(hi, per);
      check("period4", per, 4); check("high4", hi, 2);
      for (int i = 0; i < 2; i++) begin
         send_cfg(1 - i);
         push("bad_cfg_err", S_ERR, 1); push("bad_div_val", S_DV, 4); push("bad_running", S_RUN, 1);
         @(negedge clk_in);
         cfg.cfg_valid = 1'b0;
         drain();
         push("bad_err_clear", S_ERR, 0); push("bad_still_run", S_RUN, 1);
         @(negedge clk_in);
         drain();
      end
      send_cfg(10);
      push("wl_busy", S_BUSY, 1); push("wl_running", S_RUN, 0); push("wl_div_rst", S_DR, 0);
      push("wl_ready", S_RDY, 0);
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0;
      drain();
      wait_for("load_reached", S_DR, 1, 20);
      check("low_on_load", div_clk_in, 0);
      n = 0;
      while (div_rst === 1'b1 && n < 20) begin @(negedge clk_in); n++; end
      check("div_rst_len", n, 3);
      push("new_div_val", S_DV, 10); push("new_running", S_RUN, 1); push("new_busy", S_BUSY, 0);
      drain();
      n = 0;
      while (div_clk_in !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
      check("first_toggle", n, 5);
      period(hi, per);
      check("period10", per, 10); check("high10", hi, 5);
      send_cfg(6); stop = 1'b1;
      push("cs_busy", S_BUSY, 1); push("cs_running", S_RUN, 0);
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0; stop = 1'b0;
      drain();
      wait_for("cs_load", S_DR, 1, 30);
      @(negedge clk_in);
      push("cs_div_val", S_DV, 6); push("cs_div_rst", S_DR, 1); push("cs_running", S_RUN, 0);
      push("cs_busy_off", S_BUSY, 0); push("cs_ready", S_RDY, 1);
      drain();
      start = 1'b1; stop = 1'b1;
      push("ss_running", S_RUN, 0); push("ss_div_rst", S_DR, 1);
      @(negedge clk_in);
      start = 1'b0; stop = 1'b0;
      drain();
      start = 1'b1;
      push("run6_running", S_RUN, 1);
      @(negedge clk_in);
      start = 1'b0;
      drain();
      period(hi, per);
      check("period6", per, 6); check("high6", hi, 3);
      send_cfg(8);
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0;
      wait_for("rs_load", S_DR, 1, 30);
      @(negedge clk_in);
      push("rs_settle_busy", S_BUSY, 1);
      drain();
      rst = 1'b1;
      push("rs_div_val", S_DV, 2); push("rs_div_rst", S_DR, 1); push("rs_busy", S_BUSY, 0);
      push("rs_running", S_RUN, 0); push("rs_ready", S_RDY, 1);
      @(negedge clk_in);
      drain();
      rst = 1'b0;
      @(negedge clk_in);
      start = 1'b1;
      push("post_rst_div_val", S_DV, 2); push("post_rst_running", S_RUN, 1);
      @(negedge clk_in);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk_in);
      stop = 1'b1;
      #1 check("ready_with_stop", cfg.cfg_ready, 0);
      push("stop_busy", S_BUSY, 1); push("stop_running", S_RUN, 0); push("stop_ready", S_RDY, 0);
      @(negedge clk_in);
      stop = 1'b0;
      drain();
      wait_for("stop_load", S_DR, 1, 20);
      @(negedge clk_in);
      push("stop_div_val", S_DV, 2); push("stop_off_running", S_RUN, 0); push("stop_off_busy", S_BUSY, 0);
      drain();
`ifdef CLKDIV_CTRL_TIMEOUT_EN
      hold_hi = 1'b1;
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      send_cfg(4);
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0;
      n = 0;
      while (timeout_err !== 1'b1 && n < 40) begin @(negedge clk_in); n++; end
      check("timeout_cycles", n, 16);
      check("timeout_load", div_rst, 1);
      @(negedge clk_in);
      check("timeout_pulse", timeout_err, 0);
      hold_hi = 1'b0;
      wait_for("timeout_run", S_RUN, 1, 10);
      check("timeout_div_val", div_val, 4);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
